// File: rtl/storage_arbiter_pkg.sv
// Shared constants, state encoding and small helpers for the storage arbiter.
package storage_arbiter_pkg;

    localparam logic [1:0] REQ_INPUT  = 2'd0;
    localparam logic [1:0] REQ_DISP   = 2'd1;
    localparam logic [1:0] REQ_CALC   = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } arb_state_t;

    // (a + b) mod 3 for requester indices; a, b are expected in 0..2.
    function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // One-hot grant vector for a requester index; OWNER_NONE gives all zeros.
    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            REQ_INPUT: v = 3'b001;
            REQ_DISP:  v = 3'b010;
            REQ_CALC:  v = 3'b100;
            default:   v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/storage_rr_pick.sv
// Combinational 3-way circular priority picker: the first requester found
// searching upward from the pointer (wrapping 2 -> 0) wins.
module storage_rr_pick
    import storage_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [1:0] o_win,
    output logic       o_any
);

    logic [1:0] w_idx;
    logic       w_hit;

    // Scan from the farthest candidate back to the pointer so the closest hit overrides.
    always_comb begin
        o_win = OWNER_NONE;
        o_any = |i_req;
        w_idx = 2'd0;
        w_hit = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            w_idx = add_mod3(i_ptr, 2'(i));
            case (w_idx)
                2'd0:    w_hit = i_req[0];
                2'd1:    w_hit = i_req[1];
                2'd2:    w_hit = i_req[2];
                default: w_hit = 1'b0;
            endcase
            if (w_hit) begin
                o_win = w_idx;
            end
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// Round-robin request/grant arbiter for the single-port matrix storage RAM.
// Grants are registered, bursts are capped at MAX_BURST beats, and read
// beats are tagged so their data comes back with a per-requester strobe.
module storage_arbiter
    import storage_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int READ_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            i_req,
    input  logic [2:0]            i_we,
    input  logic [3*ADDR_W-1:0]   i_addr,
    input  logic [3*DATA_W-1:0]   i_wdata,
    output logic [2:0]            o_gnt,
    output logic [2:0]            o_rvalid,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [1:0]            o_owner,
    output logic                  o_storage_we,
    output logic [ADDR_W-1:0]     o_storage_addr,
    output logic [DATA_W-1:0]     o_storage_data,
    input  logic [DATA_W-1:0]     i_storage_rdata
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam int         LAST_STAGE = READ_LAT - 1;

    arb_state_t r_state, w_state_next;
    logic [2:0] r_gnt,   w_gnt_next;
    logic [1:0] r_owner, w_owner_next;
    logic [1:0] r_ptr,   w_ptr_next;
    logic [7:0] r_beat,  w_beat_next;

    logic       r_tag_vld [READ_LAT];
    logic [1:0] r_tag     [READ_LAT];

    logic [1:0] w_win;
    logic       w_any;
    logic       w_beat;
    logic       w_own_we;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_data;

    storage_rr_pick u_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    // A beat needs the owner to still be requesting; grant is one-hot so the AND suffices.
    assign w_beat = (r_state == S_OWN) && |(r_gnt & i_req);

    // One-hot mux of the owner's beat inputs; other requesters never reach the RAM.
    always_comb begin
        w_own_we   = 1'b0;
        w_own_addr = '0;
        w_own_data = '0;
        for (int k = 0; k < 3; k++) begin
            if (r_gnt[k]) begin
                w_own_we   = i_we[k];
                w_own_addr = i_addr[k*ADDR_W +: ADDR_W];
                w_own_data = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: grant from idle, count beats, release on drop or burst cap.
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_beat_next  = r_beat;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_OWN;
                    w_gnt_next   = idx_onehot(w_win);
                    w_owner_next = w_win;
                    w_beat_next  = 8'd0;
                end
            end
            S_OWN: begin
                if (!w_beat || (r_beat == BURST_LAST)) begin
                    // Release always forces one idle cycle before the next grant.
                    w_state_next = S_IDLE;
                    w_gnt_next   = 3'b000;
                    w_owner_next = OWNER_NONE;
                    w_ptr_next   = add_mod3(r_owner, 2'd1);
                    w_beat_next  = 8'd0;
                end else begin
                    w_beat_next = r_beat + 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_gnt_next   = 3'b000;
                w_owner_next = OWNER_NONE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 3'b000;
            r_owner <= OWNER_NONE;
            r_ptr   <= REQ_INPUT;
            r_beat  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
            r_beat  <= w_beat_next;
        end
    end

    // First tag stage captures the owner of each read beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld[0] <= 1'b0;
            r_tag[0]     <= 2'd0;
        end else begin
            r_tag_vld[0] <= w_beat && !w_own_we;
            r_tag[0]     <= r_owner;
        end
    end

    generate
        for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_tag_pipe
            // Delay the read tag to line up with the RAM read latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_vld[gi] <= 1'b0;
                    r_tag[gi]     <= 2'd0;
                end else begin
                    r_tag_vld[gi] <= r_tag_vld[gi-1];
                    r_tag[gi]     <= r_tag[gi-1];
                end
            end
        end
    endgenerate

    // Decode the oldest tag into the per-requester valid strobe.
    always_comb begin
        o_rvalid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            o_rvalid[k] = r_tag_vld[LAST_STAGE] && (r_tag[LAST_STAGE] == 2'(k));
        end
    end

    assign o_rdata        = i_storage_rdata;
    assign o_gnt          = r_gnt;
    assign o_owner        = r_owner;
    assign o_storage_we   = w_beat && w_own_we;
    assign o_storage_addr = w_beat ? w_own_addr : '0;
    assign o_storage_data = w_beat ? w_own_data : '0;

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench: a vector table for write/read/release/reset behaviour on a
// MAX_BURST=16 instance, plus loops for the burst cap and for round-robin on
// a MAX_BURST=2 instance. Both instances share stimulus.
module tb_storage_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;

    logic [2:0]    a_gnt, a_rv, b_gnt, b_rv;
    logic [1:0]    a_own, b_own;
    logic [DW-1:0] a_rdata, b_rdata, a_ram_rdata, b_ram_rdata;
    logic          a_swe, b_swe;
    logic [AW-1:0] a_saddr, b_saddr;
    logic [DW-1:0] a_sdata, b_sdata;

    logic [DW-1:0] mem_a [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    storage_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .READ_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(a_gnt), .o_rvalid(a_rv), .o_rdata(a_rdata), .o_owner(a_own),
        .o_storage_we(a_swe), .o_storage_addr(a_saddr), .o_storage_data(a_sdata),
        .i_storage_rdata(a_ram_rdata)
    );

    storage_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(2), .READ_LAT(1)) u_dut_b (
        .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(b_gnt), .o_rvalid(b_rv), .o_rdata(b_rdata), .o_owner(b_own),
        .o_storage_we(b_swe), .o_storage_addr(b_saddr), .o_storage_data(b_sdata),
        .i_storage_rdata(b_ram_rdata)
    );

    // RAM model, latency 1; addresses below 0x10 read as fixed preloaded contents.
    always @(posedge clk) begin
        if (a_swe) mem_a[a_saddr] <= a_sdata;
        a_ram_rdata <= (a_saddr < 8'h10) ? {16'h1234, 8'h00, a_saddr} : mem_a[a_saddr];
        b_ram_rdata <= {24'h0, b_saddr};
    end

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        int          who;
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [2:0]  e_gnt;
        logic [1:0]  e_own;
        logic        e_swe;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_rv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic r, logic [2:0] rq, int w, logic wen, logic [7:0] a,
                                logic [31:0] d, logic [2:0] eg, logic [1:0] eo, logic es,
                                logic [7:0] ea, logic [31:0] ed, logic [2:0] ev, logic [31:0] er);
        vec_t v;
        v.rst = r; v.req = rq; v.who = w; v.we = wen; v.a = a; v.d = d;
        v.e_gnt = eg; v.e_own = eo; v.e_swe = es; v.e_addr = ea; v.e_data = ed;
        v.e_rv = ev; v.e_rdata = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Requester `who` sees (we, a, d); the others see inverted values so a bad mux shows.
    task automatic drive(input vec_t v);
        rst = v.rst;
        req = v.req;
        for (int k = 0; k < 3; k++) begin
            we[k]              = (k == v.who) ? v.we : ~v.we;
            addr[k*AW +: AW]   = (k == v.who) ? v.a  : ~v.a;
            wdata[k*DW +: DW]  = (k == v.who) ? v.d  : ~v.d;
        end
    endtask

    task automatic drive_all(input logic r, input logic [2:0] rq);
        rst = r;
        req = rq;
        we  = 3'b111;
        for (int k = 0; k < 3; k++) begin
            addr[k*AW +: AW]  = 8'(8'h40 + k);
            wdata[k*DW +: DW] = 32'(32'hD0 + k);
        end
    endtask

    initial begin
        logic [2:0] eg;
        logic [1:0] eo;
        int beats;

        //                r    req     who we a      d              gnt     own  swe addr   data          rv      rdata
        tbl[0]  = mk(1'b1, 3'b000, 0, 0, 8'h00, 32'h0,        3'b000, 2'd3, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[1]  = mk(1'b0, 3'b100, 2, 1, 8'h10, 32'hA0,       3'b000, 2'd3, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[2]  = mk(1'b0, 3'b100, 2, 1, 8'h10, 32'hA0,       3'b100, 2'd2, 1, 8'h10, 32'hA0,       3'b000, 32'h0);
        tbl[3]  = mk(1'b0, 3'b100, 2, 1, 8'h11, 32'hA1,       3'b100, 2'd2, 1, 8'h11, 32'hA1,       3'b000, 32'h0);
        tbl[4]  = mk(1'b0, 3'b100, 2, 1, 8'h12, 32'hA2,       3'b100, 2'd2, 1, 8'h12, 32'hA2,       3'b000, 32'h0);
        tbl[5]  = mk(1'b0, 3'b100, 2, 1, 8'h13, 32'hA3,       3'b100, 2'd2, 1, 8'h13, 32'hA3,       3'b000, 32'h0);
        tbl[6]  = mk(1'b0, 3'b000, 2, 1, 8'h14, 32'hA4,       3'b100, 2'd2, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[7]  = mk(1'b0, 3'b000, 2, 1, 8'h14, 32'hA4,       3'b000, 2'd3, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[8]  = mk(1'b0, 3'b010, 1, 0, 8'h05, 32'h0,        3'b000, 2'd3, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[9]  = mk(1'b0, 3'b010, 1, 0, 8'h05, 32'h0,        3'b010, 2'd1, 0, 8'h05, 32'h0,        3'b000, 32'h0);
        tbl[10] = mk(1'b0, 3'b010, 1, 0, 8'h06, 32'h0,        3'b010, 2'd1, 0, 8'h06, 32'h0,        3'b010, 32'h12340005);
        tbl[11] = mk(1'b0, 3'b100, 2, 1, 8'h20, 32'hB0,       3'b010, 2'd1, 0, 8'h00, 32'h0,        3'b010, 32'h12340006);
        tbl[12] = mk(1'b0, 3'b100, 2, 1, 8'h20, 32'hB0,       3'b000, 2'd3, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[13] = mk(1'b0, 3'b100, 2, 1, 8'h20, 32'hB0,       3'b100, 2'd2, 1, 8'h20, 32'hB0,       3'b000, 32'h0);
        tbl[14] = mk(1'b0, 3'b100, 2, 1, 8'h21, 32'hB1,       3'b100, 2'd2, 1, 8'h21, 32'hB1,       3'b000, 32'h0);
        tbl[15] = mk(1'b1, 3'b100, 2, 1, 8'h22, 32'hB2,       3'b100, 2'd2, 1, 8'h22, 32'hB2,       3'b000, 32'h0);
        tbl[16] = mk(1'b0, 3'b101, 0, 1, 8'h30, 32'hC0,       3'b000, 2'd3, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[17] = mk(1'b0, 3'b101, 0, 1, 8'h30, 32'hC0,       3'b001, 2'd0, 1, 8'h30, 32'hC0,       3'b000, 32'h0);
        tbl[18] = mk(1'b0, 3'b000, 0, 1, 8'h31, 32'hC1,       3'b001, 2'd0, 0, 8'h00, 32'h0,        3'b000, 32'h0);
        tbl[19] = mk(1'b0, 3'b000, 0, 1, 8'h31, 32'hC1,       3'b000, 2'd3, 0, 8'h00, 32'h0,        3'b000, 32'h0);

        drive_all(1'b1, 3'b000);
        repeat (2) @(posedge clk);
        #1;

        // Vector table on the MAX_BURST=16 instance.
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            $display("vec %0d: req=%b gnt=%b own=%0d swe=%b addr=%h data=%h rv=%b rdata=%h",
                     i, tbl[i].req, a_gnt, a_own, a_swe, a_saddr, a_sdata, a_rv, a_rdata);
            chk($sformatf("v%0d_gnt", i),   64'(a_gnt),   64'(tbl[i].e_gnt));
            chk($sformatf("v%0d_owner", i), 64'(a_own),   64'(tbl[i].e_own));
            chk($sformatf("v%0d_swe", i),   64'(a_swe),   64'(tbl[i].e_swe));
            chk($sformatf("v%0d_saddr", i), 64'(a_saddr), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d_sdata", i), 64'(a_sdata), 64'(tbl[i].e_data));
            chk($sformatf("v%0d_rvalid", i), 64'(a_rv),   64'(tbl[i].e_rv));
            if (tbl[i].e_rv != 3'b000)
                chk($sformatf("v%0d_rdata", i), 64'(a_rdata), 64'(tbl[i].e_rdata));
            @(posedge clk);
            #1;
        end

        // Burst cap: input alone, 16 beats, one idle cycle, re-grant, 16 more beats.
        drive_all(1'b1, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        drive_all(1'b0, 3'b001);
        beats = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            eg = (c == 0 || c == 17 || c == 34) ? 3'b000 : 3'b001;
            $display("burst cyc %0d: gnt=%b swe=%b", c, a_gnt, a_swe);
            chk($sformatf("burst_c%0d_gnt", c), 64'(a_gnt), 64'(eg));
            chk($sformatf("burst_c%0d_swe", c), 64'(a_swe), 64'(eg != 3'b000));
            if (a_swe) beats++;
            @(posedge clk);
            #1;
        end
        chk("burst_total_beats", 64'(beats), 64'd32);

        // Round robin on the MAX_BURST=2 instance: grant order 0,1,2,0 with idle gaps.
        drive_all(1'b1, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        drive_all(1'b0, 3'b111);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            eo = (c % 3 == 0) ? 2'd3 : 2'((c / 3) % 3);
            eg = (c % 3 == 0) ? 3'b000 : 3'(3'b001 << ((c / 3) % 3));
            $display("rr cyc %0d: gnt=%b own=%0d swe=%b addr=%h", c, b_gnt, b_own, b_swe, b_saddr);
            chk($sformatf("rr_c%0d_gnt", c),   64'(b_gnt),   64'(eg));
            chk($sformatf("rr_c%0d_owner", c), 64'(b_own),   64'(eo));
            chk($sformatf("rr_c%0d_swe", c),   64'(b_swe),   64'(eg != 3'b000));
            chk($sformatf("rr_c%0d_saddr", c), 64'(b_saddr),
                64'((eg != 3'b000) ? 8'(8'h40 + eo) : 8'h00));
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
